// File: rtl/column_sum_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// column_sum_accumulator_pkg
// Shared types and width helpers for the J-row adder tree and the
// column_sum_accumulator downstream stage.
//   acc_state_e : pass state (IDLE, ACCUM, HOLD)
//   in_width    : width of one upstream column sum
//   acc_width   : width that holds num_batches worst-case column sums
// -----------------------------------------------------------------------------
package column_sum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    // J element, times 2*sigma (one extra magnitude bit plus sign headroom),
    // summed over 2**levels rows by the upstream tree.
    function automatic int in_width(input int data_width, input int levels);
        return data_width + 2 + levels;
    endfunction

    // Enough growth bits that num_batches worst-case inputs cannot overflow.
    function automatic int acc_width(input int in_w, input int num_batches);
        return in_w + $clog2(num_batches + 1);
    endfunction

endpackage

// File: rtl/column_sum_accumulator_signed_accumulator.sv
// -----------------------------------------------------------------------------
// signed_accumulator
// One column of the local-field accumulator.
//   clk   in  : clock
//   rst_n in  : synchronous active-low reset, clears the sum
//   clr   in  : clear the sum to 0
//   load  in  : replace the sum with sign-extended din (wins over clr/add)
//   add   in  : add sign-extended din to the sum
//   din   in  : signed column sum, IN_W bits
//   acc   out : registered signed sum, ACC_W bits
// -----------------------------------------------------------------------------
module signed_accumulator #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] din_ext;

    assign din_ext = {{(ACC_W - IN_W){din[IN_W-1]}}, din};

    always_ff @(posedge clk) begin
        // NOTE: this is a bank of ordinary flops, not a RAM, so it takes the
        // reset like any other state; a reset mid-pass must discard the sum.
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            acc_q <= '0;
        end else if (load) begin
            acc_q <= din_ext;
        end else if (clr) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= acc_q + din_ext;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/column_sum_accumulator.sv
// -----------------------------------------------------------------------------
// column_sum_accumulator
// Accumulates NUM_BATCHES upstream column-sum vectors into the local-field
// vector h[c] and presents it to the spin-update stage with valid/ready.
//   clk            in  : clock
//   rst_n          in  : synchronous active-low reset
//   start          in  : begin a new pass (clears sums and batch count)
//   col_sums_in    in  : VECTOR_SIZE signed column sums, IN_WIDTH bits each
//   col_sums_valid in  : one-cycle qualifier for col_sums_in (upstream done)
//   acc_out        out : VECTOR_SIZE signed accumulated sums, ACC_WIDTH bits
//   acc_valid      out : acc_out holds a complete pass
//   acc_ready      in  : consumer accepts acc_out
//   busy           out : pass in progress (ACCUM)
//   batch_count    out : batches absorbed in the current pass
//   drop_err       out : sticky, a valid beat arrived outside ACCUM
// -----------------------------------------------------------------------------
module column_sum_accumulator
    import column_sum_accumulator_pkg::*;
#(
    parameter int VECTOR_SIZE = 256,
    parameter int DATA_WIDTH  = 4,
    parameter int LEVELS      = 2,
    parameter int NUM_BATCHES = 64,
    parameter int IN_WIDTH    = in_width(DATA_WIDTH, LEVELS),
    parameter int ACC_WIDTH   = acc_width(IN_WIDTH, NUM_BATCHES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic signed [IN_WIDTH-1:0]     col_sums_in [VECTOR_SIZE],
    input  logic                           col_sums_valid,
    output logic signed [ACC_WIDTH-1:0]    acc_out [VECTOR_SIZE],
    output logic                           acc_valid,
    input  logic                           acc_ready,
    output logic                           busy,
    output logic [$clog2(NUM_BATCHES+1)-1:0] batch_count,
    output logic                           drop_err
);

    localparam int CNT_W = $clog2(NUM_BATCHES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BATCHES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             valid_q, busy_q;

    // Column datapath controls, shared by every column.
    logic acc_clr, acc_load, acc_add;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        drop_d   = drop_q;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;

        if (start) begin
            // start overrides any state; a coincident beat is batch 1.
            state_d = ACCUM;
            drop_d  = 1'b0;
            if (col_sums_valid) begin
                acc_load = 1'b1;
                count_d  = CNT_ONE;
                if (NUM_BATCHES == 1) begin
                    state_d = HOLD;
                end
            end else begin
                acc_clr = 1'b1;
                count_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (col_sums_valid) begin
                        drop_d = 1'b1;
                    end
                end
                ACCUM: begin
                    if (col_sums_valid) begin
                        acc_add = 1'b1;
                        count_d = count_q + CNT_ONE;
                        if (count_q == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (col_sums_valid) begin
                        drop_d = 1'b1;
                    end
                    if (acc_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            // Status flags are registered from the next state so they line up
            // with state_q without a decode on the output path.
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d == ACCUM);
        end
    end

    for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_col
        signed_accumulator #(
            .IN_W  (IN_WIDTH),
            .ACC_W (ACC_WIDTH)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (acc_clr),
            .load  (acc_load),
            .add   (acc_add),
            .din   (col_sums_in[c]),
            .acc   (acc_out[c])
        );
    end

    assign acc_valid   = valid_q;
    assign busy        = busy_q;
    assign batch_count = count_q;
    assign drop_err    = drop_q;

endmodule

// File: tb/tb_column_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_column_sum_accumulator
// Directed bench for column_sum_accumulator with VECTOR_SIZE=4, DATA_WIDTH=4,
// LEVELS=2, NUM_BATCHES=3 (IN_WIDTH=8, ACC_WIDTH=10). Inputs change 1 time
// unit after a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_column_sum_accumulator;

    localparam int VS  = 4;
    localparam int NB  = 3;
    localparam int IW  = 8;
    localparam int AW  = 10;
    localparam int CW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic signed [IW-1:0] col_sums_in [VS];
    logic                 col_sums_valid;
    logic signed [AW-1:0] acc_out [VS];
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 busy;
    logic [CW-1:0]        batch_count;
    logic                 drop_err;

    int checks = 0;
    int errors = 0;

    column_sum_accumulator #(
        .VECTOR_SIZE (VS),
        .DATA_WIDTH  (4),
        .LEVELS      (2),
        .NUM_BATCHES (NB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .col_sums_in    (col_sums_in),
        .col_sums_valid (col_sums_valid),
        .acc_out        (acc_out),
        .acc_valid      (acc_valid),
        .acc_ready      (acc_ready),
        .busy           (busy),
        .batch_count    (batch_count),
        .drop_err       (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
        int e [VS];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < VS; i++) begin
            check($sformatf("%s.acc_out[%0d]", tag, i), acc_out[i], e[i]);
        end
    endtask

    task automatic check_ctl(input string tag, input int valid, input int bsy,
                             input int cnt, input int drop);
        check({tag, ".acc_valid"}, {31'd0, acc_valid}, valid);
        check({tag, ".busy"}, {31'd0, busy}, bsy);
        check({tag, ".batch_count"}, {30'd0, batch_count}, cnt);
        check({tag, ".drop_err"}, {31'd0, drop_err}, drop);
    endtask

    task automatic set_sums(input int a, input int b, input int c, input int d);
        col_sums_in[0] = IW'(a);
        col_sums_in[1] = IW'(b);
        col_sums_in[2] = IW'(c);
        col_sums_in[3] = IW'(d);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        col_sums_valid = 1'b0;
        acc_ready      = 1'b0;
        set_sums(0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_vec("reset", 0, 0, 0, 0);
        check_ctl("reset", 0, 0, 0, 0);

        // Beat in IDLE is dropped and flagged.
        set_sums(5, 5, 5, 5);
        col_sums_valid = 1'b1;
        tick();
        col_sums_valid = 1'b0;
        check_vec("idle_drop", 0, 0, 0, 0);
        check_ctl("idle_drop", 0, 0, 0, 1);

        // Pass 1: separate start, then three beats.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_vec("p1_start", 0, 0, 0, 0);
        check_ctl("p1_start", 0, 1, 0, 0);
        col_sums_valid = 1'b1;
        set_sums(1, -2, 3, -4);
        tick();
        check_vec("p1_b1", 1, -2, 3, -4);
        check_ctl("p1_b1", 0, 1, 1, 0);
        set_sums(10, 20, -30, 0);
        tick();
        check_vec("p1_b2", 11, 18, -27, -4);
        check_ctl("p1_b2", 0, 1, 2, 0);
        set_sums(-128, 127, 5, 5);
        tick();
        col_sums_valid = 1'b0;
        check_vec("p1_b3", -117, 145, -22, 1);
        check_ctl("p1_b3", 1, 0, 3, 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check_vec("p1_xfer", -117, 145, -22, 1);
        check_ctl("p1_xfer", 0, 0, 3, 0);

        // Pass 2: start with the first beat, all -128 (negative worst case).
        start = 1'b1;
        col_sums_valid = 1'b1;
        set_sums(-128, -128, -128, -128);
        tick();
        start = 1'b0;
        check_vec("p2_b1", -128, -128, -128, -128);
        check_ctl("p2_b1", 0, 1, 1, 0);
        tick();
        check_ctl("p2_b2", 0, 1, 2, 0);
        tick();
        col_sums_valid = 1'b0;
        check_vec("p2_b3", -384, -384, -384, -384);
        check_ctl("p2_b3", 1, 0, 3, 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check_ctl("p2_xfer", 0, 0, 3, 0);

        // Pass 3: positive worst case, all 127.
        start = 1'b1;
        col_sums_valid = 1'b1;
        set_sums(127, 127, 127, 127);
        tick();
        start = 1'b0;
        tick();
        tick();
        col_sums_valid = 1'b0;
        check_vec("p3_b3", 381, 381, 381, 381);
        check_ctl("p3_b3", 1, 0, 3, 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check_ctl("p3_xfer", 0, 0, 3, 0);

        // Restart mid-pass with a coincident beat: old partial discarded.
        start = 1'b1;
        tick();
        start = 1'b0;
        col_sums_valid = 1'b1;
        set_sums(1, 1, 1, 1);
        tick();
        check_vec("mid_b1", 1, 1, 1, 1);
        start = 1'b1;
        set_sums(7, 7, 7, 7);
        tick();
        start = 1'b0;
        check_vec("restart", 7, 7, 7, 7);
        check_ctl("restart", 0, 1, 1, 0);
        set_sums(0, 0, 0, 0);
        tick();
        tick();
        col_sums_valid = 1'b0;
        check_vec("restart_hold", 7, 7, 7, 7);
        check_ctl("restart_hold", 1, 0, 3, 0);

        // Back-pressure in HOLD, with a stray beat on cycle 5.
        for (int i = 0; i < 10; i++) begin
            col_sums_valid = (i == 5);
            set_sums(9, 9, 9, 9);
            tick();
            check($sformatf("bp%0d.acc_valid", i), {31'd0, acc_valid}, 1);
            check($sformatf("bp%0d.acc_out[0]", i), acc_out[0], 7);
        end
        col_sums_valid = 1'b0;
        check_vec("bp_end", 7, 7, 7, 7);
        check_ctl("bp_end", 1, 0, 3, 1);

        // Start in HOLD clears and re-enters ACCUM; ready alongside is ignored.
        start = 1'b1;
        acc_ready = 1'b1;
        tick();
        start = 1'b0;
        acc_ready = 1'b0;
        check_vec("hold_start", 0, 0, 0, 0);
        check_ctl("hold_start", 0, 1, 0, 0);

        // Reset after two beats.
        col_sums_valid = 1'b1;
        set_sums(2, 2, 2, 2);
        tick();
        tick();
        col_sums_valid = 1'b0;
        check_vec("pre_rst", 4, 4, 4, 4);
        check_ctl("pre_rst", 0, 1, 2, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_vec("mid_rst", 0, 0, 0, 0);
        check_ctl("mid_rst", 0, 0, 0, 0);

        // Fresh pass after reset.
        start = 1'b1;
        col_sums_valid = 1'b1;
        set_sums(1, 2, 3, 4);
        tick();
        start = 1'b0;
        set_sums(10, 10, 10, 10);
        tick();
        set_sums(-1, -1, -1, -1);
        tick();
        col_sums_valid = 1'b0;
        check_vec("post_rst", 10, 11, 12, 13);
        check_ctl("post_rst", 1, 0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_sum_accumulator.md
# column_sum_accumulator

Downstream stage of the J-row adder-tree block. It consumes one vector of signed column partial sums per row batch, qualified by the upstream `done` pulse. Over `NUM_BATCHES` batches it accumulates them into a full local-field vector h[c] = Σ_r 2·σ_r·J[r][c], then holds the result behind a valid/ready handshake for the spin-update stage.

## Interface
- `VECTOR_SIZE`, 256: columns per vector; must match the upstream block.
- `DATA_WIDTH`, 4: J element width; must match upstream.
- `LEVELS`, 2: upstream adder-tree depth, clog2(NUM_ROWS).
- `NUM_BATCHES`, 64: row batches per pass; ≥1.
- `IN_WIDTH`, DATA_WIDTH+2+LEVELS: input sum width (derived; do not override).
- `ACC_WIDTH`, IN_WIDTH+$clog2(NUM_BATCHES+1): accumulator width (derived).
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begins a new pass; clears the accumulators and the batch counter.
- `col_sums_in`  in  signed [IN_WIDTH-1:0] x [0:VECTOR_SIZE-1]: upstream column sums.
- `col_sums_valid`  in  1: one-cycle qualifier for `col_sums_in`; this is the upstream `done`.
- `acc_out`  out  signed [ACC_WIDTH-1:0] x [0:VECTOR_SIZE-1]: accumulated local fields.
- `acc_valid`  out  1: `acc_out` holds a complete pass.
- `acc_ready`  in  1: consumer accepts `acc_out`.
- `busy`  out  1: high in ACCUM.
- `batch_count`  out  [$clog2(NUM_BATCHES+1)-1:0]: batches absorbed in the current pass.
- `drop_err`  out  1: sticky flag; a valid beat arrived outside ACCUM.

## Operation
- States: IDLE, ACCUM, HOLD. All outputs are registered.
- Reset (synchronous, `rst_n`=0 at a clock edge): state IDLE, `acc_out` all 0, `batch_count` 0, `acc_valid` 0, `busy` 0, `drop_err` 0.
- `start`=1 in any state:
  - Next state ACCUM.
  - All `acc_out` cleared to 0 and `batch_count` cleared to 0.
  - `drop_err` cleared and `acc_valid` dropped.
  - `start` takes priority over `acc_ready` and over any HOLD content.
- `start` and `col_sums_valid` in the same cycle: the beat counts as batch 1 of the new pass. `acc_out` loads the sign-extended input and `batch_count` becomes 1.
- ACCUM with `col_sums_valid`=1: each `acc_out[c]` += sign-extended `col_sums_in[c]`, and `batch_count` increments.
  - If the beat is the NUM_BATCHES-th, the next state is HOLD.
  - ACCUM with `col_sums_valid`=0: hold all state.
- HOLD:
  - `acc_valid`=1 and `acc_out` is stable.
  - `acc_ready`=1 transfers the vector; next state IDLE, `acc_valid` 0. `acc_out` keeps its value until the next `start`.
- `col_sums_valid` in IDLE or HOLD without `start`: the beat is discarded, `drop_err` is set, and accumulators are untouched.
- Arithmetic: two's-complement with full sign extension. ACC_WIDTH guarantees no overflow for NUM_BATCHES worst-case inputs, so there is no saturation or wrap.
- NUM_BATCHES=1: a single valid beat in ACCUM goes directly to HOLD.

## Timing
- The accumulate update is visible on `acc_out` the cycle after the valid beat.
- `acc_valid` rises the cycle after the final batch beat.
- Start-to-`acc_valid` latency with back-to-back beats is NUM_BATCHES cycles; it is longer if upstream stalls.
- Handshake: the transfer occurs at an edge with `acc_valid`&&`acc_ready`. `acc_ready` while `acc_valid`=0 is ignored.
- `busy` is high exactly while the state is ACCUM.
- `batch_count` reads NUM_BATCHES while in HOLD.
- Reset asserted mid-pass: the partial sum is discarded and all outputs return to their reset values at that edge.

## Structure
- A shared package holds:
  - the `acc_state_e` enum (IDLE, ACCUM, HOLD);
  - the width helper functions `in_width(DATA_WIDTH, LEVELS)` and `acc_width(in_w, NUM_BATCHES)`, which the upstream block also reuses.
- Sub-module `signed_accumulator`: one per column (generate loop), with `clr`, `load`, `add`, and a parameterized width. The top level holds the FSM, `batch_count` and `drop_err`.

## Test plan
Bench parameters: VECTOR_SIZE=4, DATA_WIDTH=4, LEVELS=2, NUM_BATCHES=3, so IN_WIDTH=8 and ACC_WIDTH=10.
- Reset then idle: all outputs are 0 and the state is IDLE. A valid beat in IDLE leaves `acc_out` at 0 and sets `drop_err`=1.
- Three back-to-back passes:
  - Stimulus: `start`, then beats {1,-2,3,-4}, {10,20,-30,0}, {-128,127,5,5}.
  - `acc_valid` rises the cycle after the 3rd beat, with `acc_out`={-117,145,-22,1}. `acc_ready`=1 then returns to IDLE.
- Worst case: 3 beats of all -128 gives -384 per column, and 3 beats of all 127 gives 381. There is no wrap.
- `start` together with a valid beat {7,7,7,7} mid-pass:
  - The old partial is discarded and `batch_count`=1 with `acc_out`={7,...}.
  - Two further zero beats lead to HOLD with {7,7,7,7}.
- Back-pressure: hold `acc_ready`=0 for 10 cycles in HOLD. `acc_out` stays stable, and an extra valid beat sets `drop_err` without changing `acc_out`. `start` in HOLD clears and re-enters ACCUM.
- Reset mid-pass: after 2 beats, `rst_n`=0 for one edge. All outputs are 0, and the next pass produces correct sums.
